// File: rtl/mba_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mba_pkg;

    localparam int unsigned MBA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        BOOTH_Z,
        BOOTH_P1,
        BOOTH_P2,
        BOOTH_M1,
        BOOTH_M2
    } booth_t;

    // Radix-4 recoding of one multiplier triplet {b[2k+1], b[2k], b[2k-1]}.
    function automatic booth_t booth_decode(input logic [2:0] triplet);
        booth_t code;
        case (triplet)
            3'b001, 3'b010: code = BOOTH_P1;
            3'b011:         code = BOOTH_P2;
            3'b100:         code = BOOTH_M2;
            3'b101, 3'b110: code = BOOTH_M1;
            default:        code = BOOTH_Z;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mba_booth_enc.sv
// Combinational Booth digit encoder: one triplet times the multiplicand,
// returned as a sign-extended WIDTH+2-bit partial product.
module mba_booth_enc
    import mba_pkg::*;
#(
    parameter int unsigned WIDTH = MBA_WIDTH
) (
    input  logic [2:0]       triplet_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH+1:0] pp_o
);

    // Two guard bits make -2 * (-2^(WIDTH-1)) representable.
    logic [WIDTH+1:0] mcand_x;
    assign mcand_x = {{2{mcand_i[WIDTH-1]}}, mcand_i};

    // Select 0, +/-1 or +/-2 times the multiplicand.
    always_comb begin
        pp_o = '0;
        case (booth_decode(triplet_i))
            BOOTH_P1: pp_o = mcand_x;
            BOOTH_P2: pp_o = mcand_x << 1;
            BOOTH_M1: pp_o = -mcand_x;
            BOOTH_M2: pp_o = -(mcand_x << 1);
            default:  pp_o = '0;
        endcase
    end

endmodule

// File: rtl/mba_seq_ctrl.sv
// Iterative radix-4 Booth multiplier with valid/ready sequencing control.
// Retires one Booth digit per clock; product is held until consumed.
module mba_seq_ctrl
    import mba_pkg::*;
#(
    parameter int unsigned WIDTH = MBA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   io_oeb
);

    localparam int unsigned STEPS  = WIDTH / 2;
    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH:0]       b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH+1:0]     pp;
    logic [2*WIDTH-1:0]   pp_ext;
    logic [2*WIDTH-1:0]   pp_shift;
    logic [2*WIDTH-1:0]   acc_sum;

    // The multiplier is stored as {b, 0} and shifted right two bits per
    // step, so the current triplet is always the low three bits.
    mba_booth_enc #(.WIDTH(WIDTH)) u_enc (
        .triplet_i (b_sh_q[2:0]),
        .mcand_i   (a_q),
        .pp_o      (pp)
    );

    assign pp_ext   = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    assign pp_shift = pp_ext << {step_q, 1'b0};
    assign acc_sum  = acc_q + pp_shift;

    assign p      = p_q;
    assign io_oeb = '0;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: if (step_q == LAST_STEP) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath next values: capture, accumulate one digit, publish product.
    always_comb begin
        a_d    = a_q;
        b_sh_d = b_sh_q;
        acc_d  = acc_q;
        step_d = step_q;
        p_d    = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = a_in;
                    b_sh_d = {b_in, 1'b0};
                    acc_d  = '0;
                    step_d = '0;
                end
            end
            CALC: begin
                acc_d  = acc_sum;
                b_sh_d = b_sh_q >> 2;
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    p_d = acc_sum;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
            step_q <= '0;
            p_q    <= '0;
        end else begin
            a_q    <= a_d;
            b_sh_q <= b_sh_d;
            acc_q  <= acc_d;
            step_q <= step_d;
            p_q    <= p_d;
        end
    end

endmodule

// File: tb/tb_mba_seq_ctrl.sv
// Scoreboard bench for mba_seq_ctrl: directed scenarios plus randomized
// operand pairs with random consumer stalls, checked against plain signed
// multiplication.
module tb_mba_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;
    logic [15:0] io_oeb;

    int          errors;
    int          checks;
    logic [15:0] exp_q[$];
    logic [15:0] held_p;
    logic        rand_phase;

    mba_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy),
        .io_oeb    (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
            return;
        end
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        exp_q.push_back(ref_mul(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = 8'($urandom);
        b_in     = 8'($urandom);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s: out_valid=0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Random consumer stalls during the randomized phase.
    always begin
        @(posedge clk); #1;
        if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every presented product against the scoreboard head,
    // and check the product register holds between results.
    always @(negedge clk) begin
        if (!reset) begin
            held_p = 16'h0000;
        end else begin
            check("io_oeb", io_oeb, 16'h0000);
            check("in_ready_vs_busy", {15'b0, in_ready}, {15'b0, ~busy});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got p=0x%04h with no product expected", p);
                end else begin
                    check("product", p, exp_q[0]);
                    if (out_ready) held_p = exp_q.pop_front();
                end
            end else begin
                check("p_hold", p, held_p);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] corner [8];

    initial begin
        errors     = 0;
        checks     = 0;
        held_p     = 16'h0000;
        rand_phase = 1'b0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a_in       = 8'h00;
        b_in       = 8'h00;
        corner     = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'h40, 8'hC0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {15'b0, out_valid}, 16'h0000);
        check("rst_in_ready",  {15'b0, in_ready},  16'h0001);
        check("rst_busy",      {15'b0, busy},      16'h0000);
        check("rst_p",         p,                  16'h0000);
        reset = 1'b1;
        @(posedge clk); #1;

        // 3 * 5: latency of exactly four edges, one-cycle pulse with out_ready high.
        send(8'd3, 8'd5);
        check("t1_in_ready_calc", {15'b0, in_ready}, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("t1_latency_valid", {15'b0, out_valid}, (k == 4) ? 16'h0001 : 16'h0000);
            check("t1_in_ready_busy", {15'b0, in_ready}, 16'h0000);
        end
        check("t1_p", p, 16'h000F);
        @(posedge clk); #1;
        check("t1_pulse_end", {15'b0, out_valid}, 16'h0000);
        check("t1_back_idle", {15'b0, in_ready}, 16'h0001);

        // Most negative squared.
        send(8'h80, 8'h80);
        wait_valid("t2_wait");
        check("t2_p", p, 16'h4000);
        @(posedge clk); #1;

        // 127 * -128, one-cycle out_valid.
        send(8'h7F, 8'h80);
        wait_valid("t3_wait");
        check("t3_p", p, 16'hC080);
        @(posedge clk); #1;
        check("t3_pulse_end", {15'b0, out_valid}, 16'h0000);
        check("t3_idle", {15'b0, in_ready}, 16'h0001);

        // Backpressure with ignored in_valid pulses.
        out_ready = 1'b0;
        send(8'hFF, 8'hFF);
        wait_valid("t4_wait");
        for (int k = 0; k < 10; k++) begin
            check("t4_hold_valid", {15'b0, out_valid}, 16'h0001);
            check("t4_hold_p", p, 16'h0001);
            in_valid = 1'b1; a_in = 8'd9; b_in = 8'd9;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_release_ready", {15'b0, in_ready}, 16'h0001);
        check("t4_release_p", p, 16'h0001);

        // Abort 100 * 100 at CALC step 2, then 7 * -3.
        send(8'd100, 8'd100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        check("t5_abort_valid", {15'b0, out_valid}, 16'h0000);
        check("t5_abort_ready", {15'b0, in_ready}, 16'h0001);
        check("t5_abort_busy", {15'b0, busy}, 16'h0000);
        check("t5_abort_p", p, 16'h0000);
        reset = 1'b1;
        @(posedge clk); #1;
        send(8'd7, 8'hFD);
        wait_valid("t5_wait");
        check("t5_p", p, 16'hFFEB);
        @(posedge clk); #1;

        // Randomized phase with consumer stalls: corners, then random pairs.
        rand_phase = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                send(corner[i], corner[j]);
            end
        end
        for (int n = 0; n < 4000; n++) begin
            send(8'($urandom), 8'($urandom));
        end
        rand_phase = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d products outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
